vga_frame_timer: RTL and testbench

Generates VGA raster timing for the pong display: pixel-rate tick, horizontal and vertical counters, sync pulses, active-video flag and frame counter. Its one-cycle end-of-visible-frame pulse drives the regfile's posEdgeScreenEnd input, so game software steps ball and paddle state once per frame. The downstream renderer uses the x/y counters to compare against ball and paddle bounds read from the regfile.

---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/pixel_tick_divider.sv | 34 +++
 rtl/vga_frame_timer.sv | 123 ++++++++++++
 tb/tb_vga_frame_timer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing constants (640x480@60 defaults) and helpers.
// Imported by the frame timer, the renderer and the regfile-side bound checks
// so that every consumer agrees on totals and sync windows.
package vga_timing_pkg;

  // Counter widths shared by every raster consumer.
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned CMP_W   = CNT_W + 1;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned DIV_W   = 3;

  // Default 640x480@60 timing.
  localparam int unsigned VGA_CLK_DIV  = 2;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  // Derived totals and sync windows (start inclusive, end exclusive).
  localparam int unsigned VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int unsigned VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int unsigned VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  // One extra bit so a window end equal to a 1024 total does not alias to 0.
  function automatic logic in_window(input logic [CMP_W-1:0] pos,
                                     input logic [CMP_W-1:0] lo,
                                     input logic [CMP_W-1:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/pixel_tick_divider.sv
// Divides the system clock down to the pixel rate.
// Ports:
//   clock      - system clock
//   reset      - synchronous active-high reset
//   enable     - when low the divider holds and no tick is produced
//   pixel_tick - high for the one clock in which the raster advances
module pixel_tick_divider
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = VGA_CLK_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic pixel_tick
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  // Tick is combinational so the counters advance on the edge closing it.
  assign pixel_tick = enable && !reset && (div == DIV_LAST);

  // Phase counter 0..CLK_DIV-1; frozen while disabled.
  always_ff @(posedge clock) begin
    if (reset) begin
      div <= '0;
    end else if (enable) begin
      div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/vga_frame_timer.sv
// VGA raster timing generator for the pong display.
// Ports:
//   clock, reset      - system clock, synchronous active-high reset
//   enable            - low freezes divider, counters and frame count
//   pixel_tick        - one-clock pixel-rate strobe
//   x, y              - raster position
//   hsync, vsync      - sync outputs, SYNC_ACTIVE level while in the sync window
//   active_video      - (x,y) is inside the visible area
//   screen_end        - one-clock pulse when (x,y) becomes (0,V_ACTIVE)
//   frame_start       - one-clock pulse when (x,y) returns to (0,0)
//   frame_count       - completed frames, wraps modulo 2^16
module vga_frame_timer
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV     = VGA_CLK_DIV,
  parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
  parameter int unsigned H_FP        = VGA_H_FP,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_BP        = VGA_H_BP,
  parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
  parameter int unsigned V_FP        = VGA_V_FP,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_BP        = VGA_V_BP,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  output logic         pixel_tick,
  output logic [9:0]   x,
  output logic [9:0]   y,
  output logic         hsync,
  output logic         vsync,
  output logic         active_video,
  output logic         screen_end,
  output logic         frame_start,
  output logic [15:0]  frame_count
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Reject parameter sets the 10-bit counters or 3-bit divider cannot hold.
  if (H_TOTAL > 1024) begin : g_bad_h_total
    $error("vga_frame_timer: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("vga_frame_timer: V_TOTAL exceeds 1024");
  end
  if ((CLK_DIV < 1) || (CLK_DIV > 8)) begin : g_bad_clk_div
    $error("vga_frame_timer: CLK_DIV outside 1..8");
  end

  logic [CNT_W-1:0] x_nxt;
  logic [CNT_W-1:0] y_nxt;
  logic             line_end;
  logic             screen_end_nxt;
  logic             frame_start_nxt;

  pixel_tick_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_pixel_tick_divider (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .pixel_tick(pixel_tick)
  );

  // Next raster position; sync/active are decoded from it so they land with x/y.
  always_comb begin
    x_nxt           = x;
    y_nxt           = y;
    line_end        = (x == CNT_W'(H_TOTAL - 1));
    screen_end_nxt  = 1'b0;
    frame_start_nxt = 1'b0;
    if (pixel_tick) begin
      if (line_end) begin
        x_nxt = '0;
        if (y == CNT_W'(V_TOTAL - 1)) begin
          y_nxt           = '0;
          frame_start_nxt = 1'b1;
        end else begin
          y_nxt = y + CNT_W'(1);
        end
        screen_end_nxt = (y == CNT_W'(V_ACTIVE - 1));
      end else begin
        x_nxt = x + CNT_W'(1);
      end
    end
  end

  // Raster state, decoded outputs and frame pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      x            <= '0;
      y            <= '0;
      hsync        <= ~SYNC_ACTIVE;
      vsync        <= ~SYNC_ACTIVE;
      active_video <= 1'b1;
      screen_end   <= 1'b0;
      frame_start  <= 1'b0;
      frame_count  <= '0;
    end else begin
      x            <= x_nxt;
      y            <= y_nxt;
      hsync        <= in_window({1'b0, x_nxt}, CMP_W'(H_SYNC_START), CMP_W'(H_SYNC_END))
                      ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync        <= in_window({1'b0, y_nxt}, CMP_W'(V_SYNC_START), CMP_W'(V_SYNC_END))
                      ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      active_video <= ({1'b0, x_nxt} < CMP_W'(H_ACTIVE)) && ({1'b0, y_nxt} < CMP_W'(V_ACTIVE));
      screen_end   <= screen_end_nxt;
      frame_start  <= frame_start_nxt;
      if (frame_start_nxt) begin
        frame_count <= frame_count + FRAME_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_timer.sv
// Bench for vga_frame_timer: two small-raster instances (CLK_DIV=2 active-low
// sync, CLK_DIV=1 active-high sync) checked every cycle against a model that
// derives the raster from the number of pixel ticks since reset.
module tb_vga_frame_timer;

  localparam int CD  [2] = '{2, 1};
  localparam int SA  [2] = '{0, 1};
  localparam int HA  [2] = '{8, 5};
  localparam int HFP [2] = '{2, 1};
  localparam int HS  [2] = '{3, 2};
  localparam int HBP [2] = '{2, 1};
  localparam int VA  [2] = '{6, 4};
  localparam int VFP [2] = '{1, 1};
  localparam int VS  [2] = '{2, 1};
  localparam int VBP [2] = '{1, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        en  [2];
  logic        pt  [2];
  logic [9:0]  xo  [2];
  logic [9:0]  yo  [2];
  logic        hs  [2];
  logic        vs  [2];
  logic        av  [2];
  logic        se  [2];
  logic        fs  [2];
  logic [15:0] fc  [2];

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: pixel ticks and enabled cycles since reset, pending pulses.
  int n    [2];
  int ecnt [2];
  bit se_m [2];
  bit fs_m [2];

  vga_frame_timer #(
    .CLK_DIV(CD[0]), .H_ACTIVE(HA[0]), .H_FP(HFP[0]), .H_SYNC(HS[0]), .H_BP(HBP[0]),
    .V_ACTIVE(VA[0]), .V_FP(VFP[0]), .V_SYNC(VS[0]), .V_BP(VBP[0]), .SYNC_ACTIVE(1'b0)
  ) dut_a (
    .clock(clk), .reset(rst[0]), .enable(en[0]), .pixel_tick(pt[0]), .x(xo[0]), .y(yo[0]),
    .hsync(hs[0]), .vsync(vs[0]), .active_video(av[0]), .screen_end(se[0]),
    .frame_start(fs[0]), .frame_count(fc[0])
  );

  vga_frame_timer #(
    .CLK_DIV(CD[1]), .H_ACTIVE(HA[1]), .H_FP(HFP[1]), .H_SYNC(HS[1]), .H_BP(HBP[1]),
    .V_ACTIVE(VA[1]), .V_FP(VFP[1]), .V_SYNC(VS[1]), .V_BP(VBP[1]), .SYNC_ACTIVE(1'b1)
  ) dut_b (
    .clock(clk), .reset(rst[1]), .enable(en[1]), .pixel_tick(pt[1]), .x(xo[1]), .y(yo[1]),
    .hsync(hs[1]), .vsync(vs[1]), .active_video(av[1]), .screen_end(se[1]),
    .frame_start(fs[1]), .frame_count(fc[1])
  );

  function automatic int ht(input int i);
    return HA[i] + HFP[i] + HS[i] + HBP[i];
  endfunction

  function automatic int vt(input int i);
    return VA[i] + VFP[i] + VS[i] + VBP[i];
  endfunction

  function automatic int frm(input int i);
    return ht(i) * vt(i);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model advance on each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst[i]) begin
          n[i] = 0; ecnt[i] = 0; se_m[i] = 1'b0; fs_m[i] = 1'b0;
        end else begin
          automatic bit tk = en[i] && ((ecnt[i] % CD[i]) == CD[i] - 1);
          if (en[i]) ecnt[i]++;
          if (tk) n[i]++;
          se_m[i] = tk && ((n[i] % frm(i)) == VA[i] * ht(i));
          fs_m[i] = tk && ((n[i] % frm(i)) == 0);
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        automatic int p   = n[i] % frm(i);
        automatic int xx  = p % ht(i);
        automatic int yy  = p / ht(i);
        automatic int hse = (xx >= HA[i] + HFP[i] && xx < HA[i] + HFP[i] + HS[i]) ? SA[i] : 1 - SA[i];
        automatic int vse = (yy >= VA[i] + VFP[i] && yy < VA[i] + VFP[i] + VS[i]) ? SA[i] : 1 - SA[i];
        automatic int pte = (en[i] && !rst[i] && ((ecnt[i] % CD[i]) == CD[i] - 1)) ? 1 : 0;
        automatic string tg = (i == 0) ? "a" : "b";
        chk({tg, ".pixel_tick"}, int'(pt[i]), pte);
        chk({tg, ".x"}, int'(xo[i]), xx);
        chk({tg, ".y"}, int'(yo[i]), yy);
        chk({tg, ".hsync"}, int'(hs[i]), hse);
        chk({tg, ".vsync"}, int'(vs[i]), vse);
        chk({tg, ".active_video"}, int'(av[i]), (xx < HA[i] && yy < VA[i]) ? 1 : 0);
        chk({tg, ".screen_end"}, int'(se[i]), int'(se_m[i]));
        chk({tg, ".frame_start"}, int'(fs[i]), int'(fs_m[i]));
        chk({tg, ".frame_count"}, int'(fc[i]), (n[i] / frm(i)) % 65536);
      end
    end
  end

  // Directed sequence with hand-computed pins, then randomized traffic.
  initial begin
    int n_fs, n_se, n_pt;
    bit found;
    rst[0] = 1'b1; rst[1] = 1'b1;
    en[0]  = 1'b0; en[1]  = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst.a.x", int'(xo[0]), 0);
    chk("rst.a.y", int'(yo[0]), 0);
    chk("rst.a.hsync", int'(hs[0]), 1);
    chk("rst.a.vsync", int'(vs[0]), 1);
    chk("rst.a.active_video", int'(av[0]), 1);
    chk("rst.a.frame_count", int'(fc[0]), 0);
    chk("rst.a.pixel_tick", int'(pt[0]), 0);
    chk("rst.b.hsync", int'(hs[1]), 0);
    chk("rst.b.vsync", int'(vs[1]), 0);

    // Release: a ticks every 2nd clock, b every clock.
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0; en[0] = 1'b1; en[1] = 1'b1;
    #1;
    chk("rel.a.pixel_tick", int'(pt[0]), 0);
    chk("rel.b.pixel_tick", int'(pt[1]), 1);

    // Two full frames of a (2 * 150 pixels * 2 clocks).
    n_fs = 0; n_se = 0; n_pt = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      #2;
      if (fs[0]) n_fs++;
      if (se[0]) n_se++;
      if (pt[0]) n_pt++;
    end
    chk("run.a.frame_start_count", n_fs, 2);
    chk("run.a.screen_end_count", n_se, 2);
    chk("run.a.pixel_tick_count", n_pt, 300);
    chk("run.a.frame_count", int'(fc[0]), 2);
    chk("run.a.x", int'(xo[0]), 0);
    chk("run.a.y", int'(yo[0]), 0);
    chk("run.b.frame_count", int'(fc[1]), 8);
    chk("run.b.x", int'(xo[1]), 6);
    chk("run.b.y", int'(yo[1]), 2);

    // Freeze a for 37 clocks.
    en[0] = 1'b0;
    n_pt = 0;
    for (int k = 0; k < 37; k++) begin
      @(negedge clk);
      #2;
      if (pt[0]) n_pt++;
    end
    chk("hold.a.pixel_tick_count", n_pt, 0);
    chk("hold.a.x", int'(xo[0]), 0);
    chk("hold.a.frame_count", int'(fc[0]), 2);
    en[0] = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("resume.a.x", int'(xo[0]), 1);

    // Reset while screen_end is high.
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      #2;
      if (se[0]) found = 1'b1;
    end
    if (!found) begin
      n_chk++; n_fail++;
      $display("FAIL wait.a.screen_end: got none expected a pulse within 400 clocks");
    end
    rst[0] = 1'b1;
    @(negedge clk);
    #2;
    chk("mid.a.x", int'(xo[0]), 0);
    chk("mid.a.y", int'(yo[0]), 0);
    chk("mid.a.screen_end", int'(se[0]), 0);
    chk("mid.a.frame_count", int'(fc[0]), 0);
    chk("mid.a.hsync", int'(hs[0]), 1);
    chk("mid.a.vsync", int'(vs[0]), 1);
    chk("mid.a.active_video", int'(av[0]), 1);
    rst[0] = 1'b0;

    // Randomized enable gaps and occasional resets.
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
        en[i]  = ($urandom_range(0, 3) != 0);
        rst[i] = ($urandom_range(0, 299) == 0);
      end
    end
    @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
